// File: rtl/rr_arb2_if.sv
// Handshake bundle for rr_arb2: two request channels (X, Y), mux select, output register port.
interface rr_arb2_if #(
    parameter int unsigned WIDTH = 8
);
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             x_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Sources and consumer side
    modport master (
        output x_valid, x_data, y_valid, y_data, out_ready,
        input  x_ready, y_ready, sel, out_valid, out_data
    );

    // Arbiter side
    modport slave (
        input  x_valid, x_data, y_valid, y_data, out_ready,
        output x_ready, y_ready, sel, out_valid, out_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-channel round-robin arbiter feeding a one-entry output register and the 2:1 mux select.
// Optional grant counters enabled by defining RR_ARB2_STATS_EN.
module rr_arb2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb2_if.slave      bus_io
`ifdef RR_ARB2_STATS_EN
    ,
    output logic [15:0]   x_grants,
    output logic [15:0]   y_grants
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               prio_q, prio_d;
    logic               sel_q, sel_d;

    logic               grant_any;
    logic               grant_y;
    logic               accept;
    logic               xfer;

    always_comb begin
        grant_any = bus_io.x_valid | bus_io.y_valid;
        // Y wins when it is the only requester, or both request and Y holds priority
        grant_y   = bus_io.y_valid & (~bus_io.x_valid | prio_q);
        accept    = (state_q == EMPTY) | bus_io.out_ready;
        xfer      = ~rst & accept & grant_any;

        state_d = state_q;
        data_d  = data_q;
        prio_d  = prio_q;
        sel_d   = sel_q;

        if (grant_any) begin
            sel_d = grant_y;
        end

        if (xfer) begin
            data_d  = grant_y ? bus_io.y_data : bus_io.x_data;
            state_d = FULL;
            prio_d  = ~grant_y;
        end else if ((state_q == FULL) && bus_io.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    assign bus_io.x_ready   = xfer & ~grant_y;
    assign bus_io.y_ready   = xfer & grant_y;
    assign bus_io.sel       = grant_any ? grant_y : sel_q;
    assign bus_io.out_valid = (state_q == FULL);
    assign bus_io.out_data  = data_q;

`ifdef RR_ARB2_STATS_EN
    logic [15:0] x_cnt_q, y_cnt_q;

    // Saturating counters: hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            if (bus_io.x_ready && (x_cnt_q != '1)) begin
                x_cnt_q <= x_cnt_q + 16'd1;
            end
            if (bus_io.y_ready && (y_cnt_q != '1)) begin
                y_cnt_q <= y_cnt_q + 16'd1;
            end
        end
    end

    assign x_grants = x_cnt_q;
    assign y_grants = y_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb2.sv
// Self-checking bench for rr_arb2: rule-level reference model checked every cycle plus directed literals.
module tb_rr_arb2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_arb2_if #(.WIDTH(8)) bus ();

`ifdef RR_ARB2_STATS_EN
    logic [15:0] x_grants, y_grants;
`endif

    rr_arb2 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_io   (bus)
`ifdef RR_ARB2_STATS_EN
        ,
        .x_grants (x_grants),
        .y_grants (y_grants)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output register as "word present or not", preferred channel, last select.
    bit       m_full = 1'b0;
    bit [7:0] m_word = 8'h00;
    bit       m_pref = 1'b0;
    bit       m_sel  = 1'b0;
    int       m_xcnt = 0;
    int       m_ycnt = 0;

    always @(negedge clk) begin
        int  g;
        bit  can_load;
        bit  exp_sel;
        if (!bus.x_valid && !bus.y_valid) g = -1;
        else if (bus.x_valid && !bus.y_valid) g = 0;
        else if (!bus.x_valid && bus.y_valid) g = 1;
        else g = m_pref ? 1 : 0;
        can_load = !m_full || bus.out_ready;
        exp_sel  = (g < 0) ? m_sel : (g == 1);

        chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
        chk("m_out_data", {24'd0, bus.out_data}, {24'd0, m_word});
        chk("m_sel", {31'd0, bus.sel}, {31'd0, exp_sel});
        chk("m_x_ready", {31'd0, bus.x_ready}, {31'd0, (!rst && can_load && g == 0)});
        chk("m_y_ready", {31'd0, bus.y_ready}, {31'd0, (!rst && can_load && g == 1)});
`ifdef RR_ARB2_STATS_EN
        chk("m_x_grants", {16'd0, x_grants}, m_xcnt);
        chk("m_y_grants", {16'd0, y_grants}, m_ycnt);
`endif

        if (rst) begin
            m_full = 0; m_word = 0; m_pref = 0; m_sel = 0; m_xcnt = 0; m_ycnt = 0;
        end else begin
            if (g >= 0) m_sel = (g == 1);
            if (can_load && g >= 0) begin
                m_word = (g == 1) ? bus.y_data : bus.x_data;
                m_full = 1;
                m_pref = (g == 0);
                if (g == 0 && m_xcnt < 65535) m_xcnt++;
                if (g == 1 && m_ycnt < 65535) m_ycnt++;
            end else if (m_full && bus.out_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] cont_exp [4];
    int xi, yi;

    initial begin
        cont_exp[0] = 8'hA0; cont_exp[1] = 8'hB0; cont_exp[2] = 8'hA1; cont_exp[3] = 8'hB1;
        bus.x_valid = 0; bus.y_valid = 0; bus.x_data = 0; bus.y_data = 0; bus.out_ready = 0;
        cyc(); cyc();
        rst = 0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out_data", {24'd0, bus.out_data}, 0);
        chk("rst_sel", {31'd0, bus.sel}, 0);
        chk("rst_readies", {30'd0, bus.x_ready, bus.y_ready}, 0);

        // X alone
        bus.x_valid = 1; bus.x_data = 8'h11; bus.out_ready = 1;
        #1;
        chk("xonly_sel", {31'd0, bus.sel}, 0);
        chk("xonly_x_ready", {31'd0, bus.x_ready}, 1);
        cyc();
        bus.x_valid = 0;
        #1;
        chk("xonly_out_valid", {31'd0, bus.out_valid}, 1);
        chk("xonly_out_data", {24'd0, bus.out_data}, 32'h11);

        // Y alone hands priority back to X
        bus.y_valid = 1; bus.y_data = 8'h22;
        #1;
        chk("yonly_y_ready", {31'd0, bus.y_ready}, 1);
        cyc();
        bus.y_valid = 0;

        // Contention
        xi = 0; yi = 0;
        for (int i = 0; i < 4; i++) begin
            bus.x_valid = 1; bus.y_valid = 1;
            bus.x_data = 8'hA0 + 8'(xi); bus.y_data = 8'hB0 + 8'(yi);
            #1;
            chk("cont_sel", {31'd0, bus.sel}, i & 1);
            cyc();
            #1;
            chk("cont_out_data", {24'd0, bus.out_data}, {24'd0, cont_exp[i]});
            chk("cont_out_valid", {31'd0, bus.out_valid}, 1);
            if ((i & 1) == 0) xi++; else yi++;
        end

        // Backpressure
        bus.y_valid = 0; bus.x_valid = 1; bus.x_data = 8'h5A;
        cyc();
        bus.out_ready = 0; bus.y_valid = 1; bus.x_data = 8'h66; bus.y_data = 8'h77;
        #1;
        chk("bp_loaded", {24'd0, bus.out_data}, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_readies", {30'd0, bus.x_ready, bus.y_ready}, 0);
            chk("bp_out_data", {24'd0, bus.out_data}, 32'h5A);
            cyc();
        end
        bus.out_ready = 1;
        #1;
        chk("bp_release_y_ready", {31'd0, bus.y_ready}, 1);
        cyc();
        #1;
        chk("bp_next_data", {24'd0, bus.out_data}, 32'h77);
        chk("bp_next_valid", {31'd0, bus.out_valid}, 1);

        // Lone requester fairness
        bus.x_valid = 0; bus.y_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.y_data = 8'h31 + 8'(i);
            #1;
            chk("lone_y_ready", {31'd0, bus.y_ready}, 1);
            cyc();
        end
        bus.x_valid = 1; bus.x_data = 8'h44; bus.y_data = 8'h55;
        #1;
        chk("fair_sel", {31'd0, bus.sel}, 0);
        chk("fair_x_ready", {31'd0, bus.x_ready}, 1);
        cyc();
        #1;
        chk("fair_out_data", {24'd0, bus.out_data}, 32'h44);

        // Reset mid-stream
        bus.y_valid = 0; bus.x_data = 8'hC3;
        cyc();
        bus.out_ready = 0; bus.y_valid = 1;
        #1;
        chk("mid_loaded", {24'd0, bus.out_data}, 32'hC3);
        rst = 1;
        #1;
        chk("mid_rst_readies", {30'd0, bus.x_ready, bus.y_ready}, 0);
        cyc();
        rst = 0;
        #1;
        chk("mid_out_valid", {31'd0, bus.out_valid}, 0);
        chk("mid_out_data", {24'd0, bus.out_data}, 0);
        bus.out_ready = 1;
        #1;
        chk("mid_first_sel", {31'd0, bus.sel}, 0);
        chk("mid_first_x_ready", {31'd0, bus.x_ready}, 1);
        cyc();

`ifdef RR_ARB2_STATS_EN
        rst = 1; bus.x_valid = 0; bus.y_valid = 0;
        cyc();
        rst = 0; bus.x_valid = 1;
        repeat (5) cyc();
        bus.x_valid = 0; bus.y_valid = 1;
        repeat (2) cyc();
        bus.y_valid = 0;
        #1;
        chk("stats_x_grants", {16'd0, x_grants}, 5);
        chk("stats_y_grants", {16'd0, y_grants}, 2);
        bus.x_valid = 1;
        repeat (65535) cyc();
        bus.x_valid = 0;
        #1;
        chk("stats_x_saturate", {16'd0, x_grants}, 32'hFFFF);
`endif

        bus.x_valid = 0; bus.y_valid = 0;
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
